conv_frame_ctrl: RTL and testbench



---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_tag_pipe.sv | 33 +++
 rtl/conv_frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_conv_frame_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the 3x3 convolution frame sequencer.
// Holds the sequencer state encoding and the derived window/result counts.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FILL,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } conv_state_e;

  localparam int IMG_W_DEF   = 28;
  localparam int IMG_H_DEF   = 28;
  localparam int K_DEF       = 3;
  localparam int ENG_LAT_DEF = 1;
  localparam int DATA_W_DEF  = 16;
  localparam int ACC_W_DEF   = 32;

  // Linear index of the first pixel that completes a KxK window.
  localparam int FIRST_VALID_IDX = (K_DEF - 1) * IMG_W_DEF + K_DEF - 1;
  localparam int N_OUT = (IMG_H_DEF - K_DEF + 1) * (IMG_W_DEF - K_DEF + 1);

endpackage

// File: rtl/conv_tag_pipe.sv
// Delay line carrying {valid,row,col} window tags alongside the engine latency.
// Cleared by reset so no stale tag survives an aborted frame.
module conv_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int RW    = 5,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_i,
  input  logic [RW-1:0] row_i,
  input  logic [CW-1:0] col_i,
  output logic          vld_o,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o
);

  localparam int TW = 1 + RW + CW;

  logic [TW-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= {vld_i, row_i, col_i};
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign {vld_o, row_o, col_o} = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the streaming 3x3 convolution engine: clears, gates and tags results.
// Optional build macro CONV_CTRL_RELU_EN clamps negative results to zero.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for start
// CLEAR    | one-cycle engine clear, row/col zeroed
// FILL     | accepting pixels, no complete window yet
// RUN      | accepting pixels, complete windows tagged
// DRAIN    | waiting out engine latency after last pixel
// DONE     | one-cycle frame_done pulse
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int K       = K_DEF,
  parameter int ENG_LAT = ENG_LAT_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  localparam int RW     = $clog2(IMG_H),
  localparam int CW     = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              eng_clr,
  output logic              eng_en,
  output logic [DATA_W-1:0] eng_data,
  input  logic [ACC_W-1:0]  eng_result,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res_data,
  output logic [RW-1:0]     res_row,
  output logic [CW-1:0]     res_col,
  output logic              busy,
  output logic              frame_done
);

  localparam int LW = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;

  conv_state_e   state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] lat_q, lat_d;

  logic          accept;
  logic          last_col;
  logic          last_pix;
  logic          win_pix;
  logic          tag_vld;
  logic [RW-1:0] tag_row;
  logic [CW-1:0] tag_col;
  logic          pipe_vld;
  logic [RW-1:0] pipe_row;
  logic [CW-1:0] pipe_col;

  assign pix_ready  = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign accept     = pix_valid & pix_ready;
  assign eng_en     = accept;
  assign eng_data   = pix_ready ? pix_data : '0;
  assign eng_clr    = (state_q == ST_CLEAR);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);

  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_pix = last_col && (row_q == RW'(IMG_H - 1));
  assign win_pix  = (row_q == RW'(K - 1)) && (col_q == CW'(K - 1));

  assign tag_vld = accept && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
  assign tag_row = tag_vld ? row_q - RW'(K - 1) : '0;
  assign tag_col = tag_vld ? col_q - CW'(K - 1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lat_d   = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        row_d   = '0;
        col_d   = '0;
        state_d = ST_FILL;
      end
      ST_FILL, ST_RUN: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (state_q == ST_FILL && win_pix) state_d = ST_RUN;
          // Drain timer counts down to zero so DRAIN lasts exactly ENG_LAT cycles.
          if (state_q == ST_RUN && last_pix) begin
            state_d = ST_DRAIN;
            lat_d   = LW'(ENG_LAT - 1);
          end
        end
      end
      ST_DRAIN: begin
        if (lat_q == '0) state_d = ST_DONE;
        else             lat_d   = lat_q - 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  conv_tag_pipe #(
    .DEPTH (ENG_LAT),
    .RW    (RW),
    .CW    (CW)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .vld_i (tag_vld),
    .row_i (tag_row),
    .col_i (tag_col),
    .vld_o (pipe_vld),
    .row_o (pipe_row),
    .col_o (pipe_col)
  );

  assign res_valid = pipe_vld;
  assign res_row   = pipe_row;
  assign res_col   = pipe_col;

  always_comb begin
    res_data = '0;
    if (pipe_vld) begin
`ifdef CONV_CTRL_RELU_EN
      res_data = eng_result[ACC_W-1] ? '0 : eng_result;
`else
      res_data = eng_result;
`endif
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Randomized bench for conv_frame_ctrl with a behavioural 3x3 engine and window reference model.
// Honours CONV_CTRL_RELU_EN when computing expected result values.
module tb_conv_frame_ctrl;
  import conv_pkg::*;

  localparam int W    = IMG_W_DEF;
  localparam int H    = IMG_H_DEF;
  localparam int KK   = K_DEF;
  localparam int LAT  = ENG_LAT_DEF;
  localparam int DW   = DATA_W_DEF;
  localparam int AW   = ACC_W_DEF;
  localparam int NPIX = W * H;
  localparam int OW   = W - KK + 1;
  localparam int OH   = H - KK + 1;
  localparam int RW   = $clog2(H);
  localparam int CW   = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          pix_ready;
  logic          eng_clr;
  logic          eng_en;
  logic [DW-1:0] eng_data;
  logic [AW-1:0] eng_result = '0;
  logic          res_valid;
  logic [AW-1:0] res_data;
  logic [RW-1:0] res_row;
  logic [CW-1:0] res_col;
  logic          busy;
  logic          frame_done;

  conv_frame_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .eng_clr    (eng_clr),
    .eng_en     (eng_en),
    .eng_data   (eng_data),
    .eng_result (eng_result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_row    (res_row),
    .res_col    (res_col),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural engine: registered 3x3 sum of the window ending at the accepted pixel.
  logic signed [DW-1:0] emem [NPIX];
  int eidx = 0;
  bit force_neg = 1'b0;

  function automatic int eng_calc(int idx, logic signed [DW-1:0] px);
    int r = idx / W;
    int c = idx % W;
    int s = 0;
    if (force_neg) return -5;
    if (r < KK - 1 || c < KK - 1) return int'(px);
    for (int dr = 0; dr < KK; dr++)
      for (int dc = 0; dc < KK; dc++)
        s += (dr == 0 && dc == 0) ? int'(px) : int'(emem[(r - dr) * W + c - dc]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (eng_clr) begin
      eidx <= 0;
    end else if (eng_en && eidx < NPIX) begin
      emem[eidx] <= eng_data;
      eng_result <= AW'(eng_calc(eidx, eng_data));
      eidx       <= eidx + 1;
    end
  end

  typedef struct {int row; int col; int data;} res_t;
  res_t expq[$];

  int res_count, done_count, clr_count, acc_count;
  int acc58_cyc, first_res_cyc, done_cyc, clr_cyc, first_acc_cyc;
  int last_row, last_col;

  always @(negedge clk) begin
    checks++;
    if (eng_en !== (pix_valid & pix_ready) || (eng_en && eng_data !== pix_data)) begin
      errors++;
      $display("FAIL eng_gate: eng_en=%0b eng_data=%0h pix_valid=%0b pix_ready=%0b pix_data=%0h",
               eng_en, eng_data, pix_valid, pix_ready, pix_data);
    end
    if (eng_clr) begin clr_count++; clr_cyc = cyc; end
    if (frame_done) begin
      done_count++;
      done_cyc = cyc;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_in_done: busy=%0b required 1", busy);
      end
    end
    if (eng_en) begin
      if (acc_count == 0) first_acc_cyc = cyc;
      if (acc_count == FIRST_VALID_IDX) acc58_cyc = cyc;
      acc_count++;
    end
    if (res_valid) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL res_extra: row=%0d col=%0d data=%0d with no result expected",
                 res_row, res_col, $signed(res_data));
      end else begin
        res_t e;
        e = expq.pop_front();
        if (res_row !== RW'(e.row) || res_col !== CW'(e.col) || res_data !== AW'(e.data)) begin
          errors++;
          $display("FAIL res_item: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                   res_row, res_col, $signed(res_data), e.row, e.col, e.data);
        end
      end
      if (res_count == 0) first_res_cyc = cyc;
      res_count++;
      last_row = int'(res_row);
      last_col = int'(res_col);
    end
  end

  task automatic check_idle_zero(input string tag);
    checks++;
    if ({pix_ready, eng_clr, eng_en, res_valid, busy, frame_done} !== 6'b0 ||
        res_data !== '0 || res_row !== '0 || res_col !== '0 || eng_data !== '0) begin
      errors++;
      $display("FAIL %s: ready=%0b clr=%0b en=%0b rv=%0b busy=%0b done=%0b rd=%0h rr=%0d rc=%0d ed=%0h required all 0",
               tag, pix_ready, eng_clr, eng_en, res_valid, busy, frame_done,
               res_data, res_row, res_col, eng_data);
    end
  endtask

  // One frame: builds image + expected results, feeds it, then checks frame-level properties.
  task automatic run_frame(input int gap_pct, input bit ramp, input int abort_at,
                           input bit start_mid, input bit tight, input string tag);
    int img[NPIX];
    int idx, budget, c0, s;
    bit acc;
    expq.delete();
    for (int i = 0; i < NPIX; i++)
      img[i] = ramp ? i : int'($urandom_range(65535)) - 32768;
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++) begin
        s = 0;
        for (int i = 0; i < KK; i++)
          for (int j = 0; j < KK; j++)
            s += img[(r + i) * W + c + j];
        if (force_neg) s = -5;
`ifdef CONV_CTRL_RELU_EN
        if (s < 0) s = 0;
`endif
        expq.push_back('{r, c, s});
      end
    res_count = 0; done_count = 0; clr_count = 0; acc_count = 0;
    acc58_cyc = -1; first_res_cyc = -1; done_cyc = -1; clr_cyc = -1; first_acc_cyc = -1;
    last_row = -1; last_col = -1;

    start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    budget = NPIX * 4 + 100;
    while (idx < NPIX && budget > 0) begin
      if (abort_at >= 0 && idx == abort_at) break;
      pix_valid = ($urandom_range(99) >= gap_pct);
      pix_data  = DW'(img[idx]);
      start     = start_mid && (idx == 400);
      @(negedge clk);
      acc = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      budget--;
    end
    pix_valid = 1'b0;
    start = 1'b0;

    if (abort_at >= 0) begin
      checks++;
      if (idx != abort_at) begin
        errors++;
        $display("FAIL %s_abort_reach: accepts=%0d required %0d", tag, idx, abort_at);
      end
      rst = 1'b1;
      #1;
      check_idle_zero({tag, "_rst_outputs"});
      @(posedge clk); #1;
      rst = 1'b0;
      expq.delete();
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (done_count != 0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_abort_done: frame_done count=%0d busy=%0b required 0 and 0", tag, done_count, busy);
      end
      return;
    end

    checks++;
    if (idx != NPIX) begin
      errors++;
      $display("FAIL %s_feed_timeout: accepts=%0d required %0d", tag, idx, NPIX);
    end
    budget = 50;
    while (done_count == 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    checks++;
    if (done_count != 1) begin
      errors++;
      $display("FAIL %s_frame_done: count=%0d required 1", tag, done_count);
    end
    checks++;
    if (res_count != OH * OW || expq.size() != 0) begin
      errors++;
      $display("FAIL %s_res_count: got %0d (left %0d) required %0d", tag, res_count, expq.size(), OH * OW);
    end
    checks++;
    if (last_row != OH - 1 || last_col != OW - 1) begin
      errors++;
      $display("FAIL %s_last_coord: got (%0d,%0d) required (%0d,%0d)", tag, last_row, last_col, OH - 1, OW - 1);
    end
    checks++;
    if (first_res_cyc - acc58_cyc != LAT) begin
      errors++;
      $display("FAIL %s_first_lat: got %0d cycles required %0d", tag, first_res_cyc - acc58_cyc, LAT);
    end
    checks++;
    if (clr_count != 1 || !(clr_cyc < first_acc_cyc)) begin
      errors++;
      $display("FAIL %s_clear: count=%0d clr_cyc=%0d first_acc=%0d required one clear before first accept",
               tag, clr_count, clr_cyc, first_acc_cyc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_after: busy=%0b required 0", tag, busy);
    end
    if (gap_pct == 0) begin
      checks++;
      if (done_cyc - c0 != 1 + NPIX + LAT + 1) begin
        errors++;
        $display("FAIL %s_latency: got %0d required %0d", tag, done_cyc - c0, 1 + NPIX + LAT + 1);
      end
    end
    if (!tight) begin
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done_count != 1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_tail: done count=%0d busy=%0b required 1 and 0", tag, done_count, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset_outputs");
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_zero("post_reset_idle");
  endtask

  task automatic test_ramp();
    run_frame(0, 1'b1, -1, 1'b0, 1'b0, "ramp");
  endtask

  task automatic test_stalls();
    run_frame(30, 1'b0, -1, 1'b0, 1'b0, "stall");
  endtask

  task automatic test_start_in_run();
    run_frame(0, 1'b0, -1, 1'b1, 1'b0, "start_run");
  endtask

  task automatic test_reset_mid_frame();
    run_frame(0, 1'b0, 300, 1'b0, 1'b0, "abort");
    run_frame(0, 1'b0, -1, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    run_frame(0, 1'b0, -1, 1'b0, 1'b1, "b2b_a");
    run_frame(10, 1'b0, -1, 1'b0, 1'b0, "b2b_b");
  endtask

  task automatic test_relu();
    force_neg = 1'b1;
    run_frame(0, 1'b0, -1, 1'b0, 1'b0, "neg_result");
    force_neg = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_stalls();
    test_start_in_run();
    test_reset_mid_frame();
    test_back_to_back();
    test_relu();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
